// File: rtl/bht_ctrl_if.sv
// Lookup, update and flush signals between a branch unit and the
// branch history table controller. q_count width follows Q_DEPTH.
interface bht_ctrl_if #(
    parameter int Q_DEPTH = 4
);
    localparam int QCW = $clog2(Q_DEPTH) + 1;

    logic           lk_valid;
    logic [8:0]     lk_pc;
    logic           lk_ready;
    logic           pred_valid;
    logic           pred_taken;
    logic           upd_valid;
    logic [8:0]     upd_pc;
    logic           upd_taken;
    logic           upd_ready;
    logic           flush;
    logic           busy;
    logic [QCW-1:0] q_count;

    modport master (
        output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, flush,
        input  lk_ready, pred_valid, pred_taken, upd_ready, busy, q_count
    );

    modport slave (
        input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, flush,
        output lk_ready, pred_valid, pred_taken, upd_ready, busy, q_count
    );
endinterface

// File: rtl/bht_ctrl.sv
// Branch history table controller: a table of M saturating N-bit counters
// with one access per cycle, shared between lookups, queued resolved-branch
// updates (read-modify-write) and a flush-triggered clear sweep.
module bht_ctrl #(
    parameter int M       = 16,
    parameter int N       = 2,
    parameter int Q_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    bht_ctrl_if.slave bus
);
    localparam int IW  = $clog2(M);
    localparam int QW  = $clog2(Q_DEPTH);
    localparam int QCW = QW + 1;
    localparam logic [N-1:0] INIT = N'((1 << (N - 1)) - 1);
    localparam logic [N-1:0] CMAX = {N{1'b1}};

    typedef enum logic {RUN, CLEAR} state_t;

    state_t         state_reg, state_next;
    logic [IW-1:0]  sweep_reg, sweep_next;
    logic [QW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [QCW-1:0] q_count_reg;
    logic [IW-1:0]  q_idx_mem [Q_DEPTH];
    logic           q_taken_mem [Q_DEPTH];
    logic           pred_valid_reg, pred_taken_reg;
    logic [N-1:0]   cnt_rd [M];

    logic           q_full, q_empty, can_accept;
    logic           lk_acc, enq, deq, q_clear;
    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic [N-1:0]   wr_data;
    logic [IW-1:0]  lk_idx, upd_idx;
    logic [N-1:0]   upd_cnt, upd_cnt_next;
    logic           head_taken;

    assign q_full     = (q_count_reg == QCW'(Q_DEPTH));
    assign q_empty    = (q_count_reg == '0);
    // A flush cycle ignores both request channels, so neither handshake completes.
    assign can_accept = (state_reg == RUN) && !q_full && !bus.flush;
    assign enq        = bus.upd_valid && can_accept;
    assign lk_idx     = bus.lk_pc[IW-1:0];
    assign upd_idx    = q_idx_mem[rd_ptr_reg];
    assign head_taken = q_taken_mem[rd_ptr_reg];
    assign upd_cnt    = cnt_rd[upd_idx];

    assign bus.lk_ready   = can_accept;
    assign bus.upd_ready  = can_accept;
    assign bus.pred_valid = pred_valid_reg;
    assign bus.pred_taken = pred_taken_reg;
    assign bus.busy       = (state_reg == CLEAR);
    assign bus.q_count    = q_count_reg;

    // Saturating increment/decrement of the counter addressed by the queue head.
    always_comb begin
        upd_cnt_next = upd_cnt;
        if (head_taken) begin
            if (upd_cnt != CMAX) upd_cnt_next = upd_cnt + N'(1);
        end else begin
            if (upd_cnt != '0) upd_cnt_next = upd_cnt - N'(1);
        end
    end

    // Next state and the single table access arbitration for this cycle.
    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        lk_acc     = 1'b0;
        deq        = 1'b0;
        q_clear    = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = upd_idx;
        wr_data    = upd_cnt_next;
        case (state_reg)
            RUN: begin
                if (bus.flush) begin
                    state_next = CLEAR;
                    sweep_next = '0;
                    q_clear    = 1'b1;
                end else if (q_full) begin
                    deq   = 1'b1;
                    wr_en = 1'b1;
                end else if (bus.lk_valid) begin
                    lk_acc = 1'b1;
                end else if (!q_empty) begin
                    deq   = 1'b1;
                    wr_en = 1'b1;
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = sweep_reg;
                wr_data = INIT;
                if (bus.flush) begin
                    sweep_next = '0;
                end else if (sweep_reg == IW'(M - 1)) begin
                    state_next = RUN;
                    sweep_next = '0;
                end else begin
                    sweep_next = sweep_reg + IW'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    // FSM state and clear sweep index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
        end
    end

    // Queue pointers and occupancy; a flush drops everything queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            q_count_reg <= '0;
        end else if (q_clear) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            q_count_reg <= '0;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + QW'(1);
            if (deq) rd_ptr_reg <= rd_ptr_reg + QW'(1);
            if (enq && !deq)      q_count_reg <= q_count_reg + QCW'(1);
            else if (!enq && deq) q_count_reg <= q_count_reg - QCW'(1);
        end
    end

    // Queue payload storage; only the table index bits of the PC are kept.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_idx_mem[wr_ptr_reg]   <= bus.upd_pc[IW-1:0];
            q_taken_mem[wr_ptr_reg] <= bus.upd_taken;
        end
    end

    // Prediction register: valid one cycle after an accepted lookup, direction held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
        end else begin
            pred_valid_reg <= lk_acc;
            if (lk_acc) pred_taken_reg <= cnt_rd[lk_idx][N-1];
        end
    end

    // Counter table held in flops so reset can restore every entry at once.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_ent
            logic [N-1:0] cnt_reg;
            // One counter entry, written by an update or by the clear sweep.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) cnt_reg <= INIT;
                else if (wr_en && (wr_idx == IW'(gi))) cnt_reg <= wr_data;
            end
            assign cnt_rd[gi] = cnt_reg;
        end
    endgenerate
endmodule
